// File: rtl/ccd_gen_pkg.sv
// Shared register map, FSM state type and MODE bit positions for the
// CCD/ADC stimulus generator.
package ccd_gen_pkg;

  localparam logic [3:0] ADDR_PERIOD_LO = 4'd0;
  localparam logic [3:0] ADDR_PERIOD_HI = 4'd1;
  localparam logic [3:0] ADDR_BLACK_LO  = 4'd2;
  localparam logic [3:0] ADDR_BLACK_HI  = 4'd3;
  localparam logic [3:0] ADDR_ACTIVE_LO = 4'd4;
  localparam logic [3:0] ADDR_ACTIVE_HI = 4'd5;
  localparam logic [3:0] ADDR_BLANK_LO  = 4'd6;
  localparam logic [3:0] ADDR_BLANK_HI  = 4'd7;
  localparam logic [3:0] ADDR_LINES_LO  = 4'd8;
  localparam logic [3:0] ADDR_LINES_HI  = 4'd9;
  localparam logic [3:0] ADDR_MODE      = 4'd10;

  localparam int MODE_CCD  = 0;
  localparam int MODE_CONT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Replaces one byte of a 16-bit register image; the odd address is the high byte.
  function automatic logic [15:0] merge_byte(input logic [15:0] cur,
                                             input logic        high,
                                             input logic [7:0]  data);
    merge_byte = high ? {data, cur[7:0]} : {cur[15:8], data};
  endfunction

endpackage

// File: rtl/ccd_pixel_timer.sv
// Pixel-period phase counter with the half/quarter/eighth comparators that
// shape the CCD clock and sample-and-hold strobes.
module ccd_pixel_timer #(
  parameter int PER_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PER_W-1:0] period,
  output logic             ph_first,
  output logic             ph_last,
  output logic             first_half,
  output logic             shp_lvl,
  output logic             shd_lvl
);

  logic [PER_W-1:0] ph;
  logic [PER_W-1:0] half;
  logic [PER_W-1:0] quarter;
  logic [PER_W-1:0] eighth;
  logic [PER_W-1:0] shd_lo;

  assign half    = period >> 1;
  assign quarter = period >> 2;
  assign eighth  = period >> 3;
  assign shd_lo  = half + eighth;

  assign ph_first   = (ph == '0);
  assign ph_last    = (ph == period - PER_W'(1));
  assign first_half = (ph < half);
  assign shp_lvl    = !((ph >= eighth) && (ph < eighth + quarter));
  assign shd_lvl    = !((ph >= shd_lo) && (ph < shd_lo + quarter));

  // Phase is parked at 0 while disabled so the first enabled cycle is ph=0.
  always_ff @(posedge clk) begin
    if (rst || !en || ph_last) begin
      ph <= '0;
    end else begin
      ph <= ph + PER_W'(1);
    end
  end

endmodule

// File: rtl/ccd_signal_gen.sv
// CCD/ADC stimulus generator: streams show-ahead FIFO pixels to the DAC and
// drives BOS CCD timing over frames of active and blanking pixels.
module ccd_signal_gen
  import ccd_gen_pkg::*;
#(
  parameter int DAC_W = 14,
  parameter int PER_W = 10,
  parameter int PIX_W = 12,
  parameter int LIN_W = 12
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic [3:0]       cfg_addr,
  input  logic [7:0]       cfg_data,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic [DAC_W-1:0] px_data,
  input  logic             px_empty,
  output logic             px_rdreq,
  output logic [DAC_W-1:0] dac_d,
  output logic             clk_fpga,
  output logic             shp_fpga,
  output logic             shd_fpga,
  output logic             hd_fpga,
  output logic             vd_fpga,
  output logic             clpob_fpga,
  output logic             busy,
  output logic             underflow,
  output logic             cfg_err,
  output logic [15:0]      frame_cnt
);

  logic [PER_W-1:0] period;
  logic [DAC_W-1:0] black;
  logic [PIX_W-1:0] active_len;
  logic [PIX_W-1:0] blank_len;
  logic [LIN_W-1:0] num_lines;
  logic [1:0]       mode;

  state_t           state;
  state_t           state_next;
  logic [PIX_W:0]   pix;
  logic [PIX_W:0]   pix_total;
  logic [LIN_W-1:0] line;
  logic [DAC_W-1:0] pix_reg;

  logic ph_first, ph_last, first_half, shp_lvl, shd_lvl;
  logic cfg_valid, start_req, start_ok;
  logic in_active, pix_last, last_line, line_end, frame_end, pix_edge;

  assign busy      = (state != ST_IDLE);
  assign cfg_valid = !period[0] && (period >= PER_W'(8)) && (active_len != '0) &&
                     (blank_len != '0) && (num_lines != '0);
  // A stop in the same cycle cancels the start entirely.
  assign start_req = cmd_start && !cmd_stop;
  assign start_ok  = start_req && !busy && cfg_valid;

  assign pix_total = {1'b0, active_len} + {1'b0, blank_len};
  assign in_active = (pix < {1'b0, active_len});
  assign pix_last  = (pix == pix_total - (PIX_W + 1)'(1));
  assign last_line = (line == num_lines - LIN_W'(1));
  assign line_end  = busy && ph_last && pix_last;
  assign frame_end = line_end && last_line;
  assign pix_edge  = busy && ph_first;
  assign px_rdreq  = !rst && pix_edge && in_active && !px_empty;

  ccd_pixel_timer #(.PER_W(PER_W)) u_timer (
    .clk        (sys_clk),
    .rst        (rst),
    .en         (busy),
    .period     (period),
    .ph_first   (ph_first),
    .ph_last    (ph_last),
    .first_half (first_half),
    .shp_lvl    (shp_lvl),
    .shd_lvl    (shd_lvl)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      period     <= '0;
      black      <= '0;
      active_len <= '0;
      blank_len  <= '0;
      num_lines  <= '0;
      mode       <= '0;
    end else if (cfg_wr && !busy) begin
      case (cfg_addr)
        ADDR_PERIOD_LO, ADDR_PERIOD_HI:
          period <= PER_W'(merge_byte(16'(period), cfg_addr[0], cfg_data));
        ADDR_BLACK_LO, ADDR_BLACK_HI:
          black <= DAC_W'(merge_byte(16'(black), cfg_addr[0], cfg_data));
        ADDR_ACTIVE_LO, ADDR_ACTIVE_HI:
          active_len <= PIX_W'(merge_byte(16'(active_len), cfg_addr[0], cfg_data));
        ADDR_BLANK_LO, ADDR_BLANK_HI:
          blank_len <= PIX_W'(merge_byte(16'(blank_len), cfg_addr[0], cfg_data));
        ADDR_LINES_LO, ADDR_LINES_HI:
          num_lines <= LIN_W'(merge_byte(16'(num_lines), cfg_addr[0], cfg_data));
        ADDR_MODE:
          mode <= cfg_data[1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A finished single frame takes precedence over a stop arriving on its last cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_ok) state_next = ST_RUN;
      ST_RUN: begin
        if (frame_end && !mode[MODE_CONT]) state_next = ST_IDLE;
        else if (cmd_stop)                 state_next = ST_DRAIN;
      end
      ST_DRAIN: if (line_end) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst || start_ok) begin
      pix  <= '0;
      line <= '0;
    end else if (busy && ph_last) begin
      if (pix_last) begin
        pix  <= '0;
        line <= last_line ? '0 : line + LIN_W'(1);
      end else begin
        pix <= pix + (PIX_W + 1)'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      pix_reg   <= '0;
      underflow <= 1'b0;
      cfg_err   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (!busy)         pix_reg <= black;
      else if (pix_edge) pix_reg <= (in_active && !px_empty) ? px_data : black;

      if (start_ok)                                  underflow <= 1'b0;
      else if (pix_edge && in_active && px_empty)    underflow <= 1'b1;

      if (start_ok)                                  cfg_err <= 1'b0;
      else if ((cfg_wr && busy) || (start_req && (busy || !cfg_valid)))
                                                     cfg_err <= 1'b1;

      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Timing pins lag the phase counter by one cycle.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      dac_d      <= '0;
      clk_fpga   <= 1'b1;
      shp_fpga   <= 1'b1;
      shd_fpga   <= 1'b1;
      hd_fpga    <= 1'b0;
      vd_fpga    <= 1'b0;
      clpob_fpga <= 1'b0;
    end else if (!busy) begin
      dac_d      <= black;
      clk_fpga   <= 1'b1;
      shp_fpga   <= 1'b1;
      shd_fpga   <= 1'b1;
      hd_fpga    <= 1'b0;
      vd_fpga    <= 1'b0;
      clpob_fpga <= 1'b0;
    end else begin
      dac_d      <= (mode[MODE_CCD] && first_half) ? black : pix_reg;
      clk_fpga   <= first_half;
      shp_fpga   <= shp_lvl;
      shd_fpga   <= shd_lvl;
      hd_fpga    <= (pix == {1'b0, active_len});
      vd_fpga    <= !in_active && (line == '0);
      clpob_fpga <= !in_active;
    end
  end

endmodule

// File: tb/tb_ccd_signal_gen.sv
// Directed bench for ccd_signal_gen: table of per-cycle output vectors for the
// plain and CCD frames, plus hand-written corner-case sequences.
module tb_ccd_signal_gen;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic        cmd_start = 1'b0;
  logic        cmd_stop = 1'b0;
  logic [13:0] px_data;
  logic        px_empty;
  logic        px_rdreq;
  logic [13:0] dac_d;
  logic        clk_fpga, shp_fpga, shd_fpga, hd_fpga, vd_fpga, clpob_fpga;
  logic        busy, underflow, cfg_err;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_fail = 0;

  // Show-ahead FIFO model: the bench pushes, the DUT pops.
  logic [13:0] fifo_mem [0:63];
  logic [5:0]  rd_ptr = '0;
  logic [5:0]  wr_ptr = '0;
  int          pop_cnt = 0;

  assign px_data  = fifo_mem[rd_ptr];
  assign px_empty = (rd_ptr == wr_ptr);

  always @(posedge sys_clk) begin
    if (px_rdreq) begin
      rd_ptr  <= rd_ptr + 6'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  always #5 sys_clk = ~sys_clk;

  ccd_signal_gen dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .cfg_wr     (cfg_wr),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cmd_start  (cmd_start),
    .cmd_stop   (cmd_stop),
    .px_data    (px_data),
    .px_empty   (px_empty),
    .px_rdreq   (px_rdreq),
    .dac_d      (dac_d),
    .clk_fpga   (clk_fpga),
    .shp_fpga   (shp_fpga),
    .shd_fpga   (shd_fpga),
    .hd_fpga    (hd_fpga),
    .vd_fpga    (vd_fpga),
    .clpob_fpga (clpob_fpga),
    .busy       (busy),
    .underflow  (underflow),
    .cfg_err    (cfg_err),
    .frame_cnt  (frame_cnt)
  );

  // Expected outputs k cycles after the start edge; bits = clk,shp,shd,hd,vd,clpob,busy,rdreq.
  typedef struct {
    int          test;
    int          k;
    logic [13:0] dac;
    logic [7:0]  bits;
  } vec_t;

  vec_t        tbl[$];
  logic [21:0] cap [0:127];

  function automatic logic [21:0] bundle();
    return {dac_d, clk_fpga, shp_fpga, shd_fpga, hd_fpga, vd_fpga, clpob_fpga, busy, px_rdreq};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic write_byte(input logic [3:0] a, input logic [7:0] d);
    cfg_wr = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge sys_clk);
    cfg_wr = 1'b0;
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [15:0] v);
    write_byte(a, v[7:0]);
    write_byte(a + 4'd1, v[15:8]);
  endtask

  task automatic apply_stimulus(input logic [15:0] period, input logic [15:0] black,
                                input logic [15:0] act, input logic [15:0] blank,
                                input logic [15:0] lines, input logic [7:0] mode);
    write_reg(4'd0, period);
    write_reg(4'd2, black);
    write_reg(4'd4, act);
    write_reg(4'd6, blank);
    write_reg(4'd8, lines);
    write_byte(4'd10, mode);
  endtask

  task automatic push_px(input logic [13:0] v);
    fifo_mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  // Returns at the falling edge of the first RUN cycle (k=1).
  task automatic pulse_start();
    cmd_start = 1'b1;
    @(negedge sys_clk);
    cmd_start = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      cap[k] = bundle();
      @(negedge sys_clk);
    end
  endtask

  task automatic check_table(input int id);
    foreach (tbl[i]) begin
      if (tbl[i].test == id) begin
        check_output($sformatf("t%0d_k%0d", id, tbl[i].k),
                     {10'b0, cap[tbl[i].k]}, {10'b0, tbl[i].dac, tbl[i].bits});
      end
    end
  endtask

  initial begin
    int base;

    // Plain frame: P=8, ACTIVE=4, BLANK=2, LINES=2, BLACK=0x100.
    tbl.push_back('{0,  1, 14'h100, 8'b11100011});
    tbl.push_back('{0,  2, 14'h100, 8'b11100010});
    tbl.push_back('{0,  3, 14'h001, 8'b10100010});
    tbl.push_back('{0,  7, 14'h001, 8'b01000010});
    tbl.push_back('{0,  9, 14'h001, 8'b01100011});
    tbl.push_back('{0, 11, 14'h002, 8'b10100010});
    tbl.push_back('{0, 34, 14'h004, 8'b11111110});
    tbl.push_back('{0, 35, 14'h100, 8'b10111110});
    tbl.push_back('{0, 42, 14'h100, 8'b11101110});
    tbl.push_back('{0, 49, 14'h100, 8'b01101111});
    tbl.push_back('{0, 51, 14'h005, 8'b10100010});
    tbl.push_back('{0, 82, 14'h008, 8'b11110110});
    tbl.push_back('{0, 96, 14'h100, 8'b01000110});
    tbl.push_back('{0, 97, 14'h100, 8'b01100100});
    tbl.push_back('{0, 98, 14'h100, 8'b11100000});
    // CCD frame: P=16, one active pixel 0x3FFF, one blank pixel, BLACK=0x100.
    tbl.push_back('{1,  1, 14'h100,  8'b11100011});
    tbl.push_back('{1,  4, 14'h100,  8'b10100010});
    tbl.push_back('{1,  8, 14'h100,  8'b11100010});
    tbl.push_back('{1, 10, 14'h3FFF, 8'b01100010});
    tbl.push_back('{1, 12, 14'h3FFF, 8'b01000010});
    tbl.push_back('{1, 16, 14'h3FFF, 8'b01100010});
    tbl.push_back('{1, 17, 14'h3FFF, 8'b01100010});
    tbl.push_back('{1, 18, 14'h100,  8'b11111110});
    tbl.push_back('{1, 33, 14'h100,  8'b01111100});
    tbl.push_back('{1, 34, 14'h100,  8'b11100000});

    repeat (3) @(negedge sys_clk);
    rst = 1'b0;
    check_output("reset_pins", {10'b0, bundle()}, {10'b0, 14'h000, 8'b11100000});
    check_output("reset_flags", {14'b0, underflow, cfg_err, frame_cnt}, 32'h0);

    $display("[TB] plain single frame");
    apply_stimulus(16'd8, 16'h100, 16'd4, 16'd2, 16'd2, 8'h00);
    for (int i = 1; i <= 8; i++) push_px(14'(i));
    cmd_start = 1'b1;
    cmd_stop = 1'b1;
    @(negedge sys_clk);
    cmd_start = 1'b0;
    cmd_stop = 1'b0;
    check_output("start_stop_idle", {30'b0, busy, cfg_err}, 32'h0);
    base = pop_cnt;
    pulse_start();
    capture(98);
    check_table(0);
    check_output("plain_pops", 32'(pop_cnt - base), 32'd8);
    check_output("plain_frames", {16'b0, frame_cnt}, 32'd1);

    $display("[TB] ccd frame");
    apply_stimulus(16'd16, 16'h100, 16'd1, 16'd1, 16'd1, 8'h01);
    push_px(14'h3FFF);
    pulse_start();
    capture(34);
    check_table(1);
    check_output("ccd_frames", {16'b0, frame_cnt}, 32'd2);

    $display("[TB] underflow");
    apply_stimulus(16'd8, 16'h0AA, 16'd4, 16'd1, 16'd1, 8'h00);
    push_px(14'h011);
    push_px(14'h022);
    push_px(14'h033);
    base = pop_cnt;
    pulse_start();
    repeat (18) @(negedge sys_clk);
    check_output("uf_third_px", {18'b0, dac_d}, 32'h033);
    check_output("uf_not_yet", {31'b0, underflow}, 32'd0);
    repeat (8) @(negedge sys_clk);
    check_output("uf_black_px", {18'b0, dac_d}, 32'h0AA);
    check_output("uf_flag", {31'b0, underflow}, 32'd1);
    repeat (14) @(negedge sys_clk);
    check_output("uf_done", {15'b0, busy, frame_cnt}, 32'd3);
    check_output("uf_pops", 32'(pop_cnt - base), 32'd3);

    $display("[TB] config errors");
    write_reg(4'd0, 16'd7);
    pulse_start();
    check_output("bad_period", {29'b0, busy, cfg_err, underflow}, 32'b011);
    apply_stimulus(16'd8, 16'h0AA, 16'd1, 16'd1, 16'd1, 8'h00);
    pulse_start();
    check_output("good_start_clears", {29'b0, busy, cfg_err, underflow}, 32'b100);
    repeat (2) @(negedge sys_clk);
    write_byte(4'd0, 8'h20);
    check_output("write_busy_err", {31'b0, cfg_err}, 32'd1);
    repeat (12) @(negedge sys_clk);
    check_output("run_len_16", {31'b0, busy}, 32'd1);
    @(negedge sys_clk);
    check_output("write_dropped", {15'b0, busy, frame_cnt}, 32'd4);

    $display("[TB] continuous stop");
    apply_stimulus(16'd8, 16'h055, 16'd2, 16'd1, 16'd3, 8'h02);
    for (int i = 0; i < 10; i++) push_px(14'h200 + 14'(i));
    base = pop_cnt;
    pulse_start();
    repeat (72) @(negedge sys_clk);
    check_output("cont_wrap", {15'b0, busy, frame_cnt}, {15'b0, 1'b1, 16'd5});
    repeat (28) @(negedge sys_clk);
    cmd_stop = 1'b1;
    @(negedge sys_clk);
    cmd_stop = 1'b0;
    repeat (18) @(negedge sys_clk);
    check_output("drain_busy", {31'b0, busy}, 32'd1);
    @(negedge sys_clk);
    check_output("drain_done", {15'b0, busy, frame_cnt}, 32'd5);
    check_output("drain_pops", 32'(pop_cnt - base), 32'd10);

    $display("[TB] reset mid-pixel");
    apply_stimulus(16'd8, 16'h0AA, 16'd2, 16'd1, 16'd1, 8'h00);
    push_px(14'h111);
    push_px(14'h222);
    pulse_start();
    repeat (3) @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    check_output("rst_pins", {10'b0, bundle()}, {10'b0, 14'h000, 8'b11100000});
    check_output("rst_flags", {14'b0, underflow, cfg_err, frame_cnt}, 32'h0);

    apply_stimulus(16'd8, 16'h0AA, 16'd1, 16'd1, 16'd1, 8'h00);
    pulse_start();
    check_output("pop_before_rst", {31'b0, px_rdreq}, 32'd1);
    base = pop_cnt;
    rst = 1'b1;
    #1;
    check_output("rdreq_in_rst", {31'b0, px_rdreq}, 32'd0);
    @(negedge sys_clk);
    rst = 1'b0;
    check_output("no_pop_in_rst", {30'b0, busy, 1'b0} | 32'(pop_cnt - base), 32'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
